// File: rtl/aes_key_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 key-schedule engine.
package aes_key_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StDone
  } state_e;

  localparam int unsigned AES_NR_128 = 10;

  // Multiply by x in GF(2^8) with the AES polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon_next(input logic [7:0] rcon);
    return xtime(rcon);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign data_o = SBOX[data_i];

endmodule

// File: rtl/aes_key_expand_last.sv
// Iterative AES-128 key schedule producing round key NR, one round per clock.
// Optional per-round key stream enabled by defining AES_RK_STREAM_EN.
module aes_key_expand_last
  import aes_key_pkg::*;
#(
  parameter int unsigned NR = AES_NR_128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] cipher_key,
  output logic         idle,
  output logic         busy,
  output logic [127:0] round_key_10,
  output logic         key_valid,
  input  logic         key_ready
`ifdef AES_RK_STREAM_EN
  ,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_valid
`endif
);

  localparam logic [3:0] NrLast = 4'(NR);

  state_e       state_q, state_d;
  logic [127:0] w_q, w_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] rk10_q, rk10_d;
  logic         valid_q, valid_d;
  logic         idle_q, idle_d;
  logic         busy_q, busy_d;

  logic [31:0]  rot_w3, sub_w3, t_word;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [127:0] w_next;

  assign rot_w3 = {w_q[23:0], w_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .data_i(rot_w3[8*i +: 8]),
      .data_o(sub_w3[8*i +: 8])
    );
  end

  assign t_word = sub_w3 ^ {rcon_q, 24'h0};
  assign w0_n   = w_q[127:96] ^ t_word;
  assign w1_n   = w_q[95:64] ^ w0_n;
  assign w2_n   = w_q[63:32] ^ w1_n;
  assign w3_n   = w_q[31:0] ^ w2_n;
  assign w_next = {w0_n, w1_n, w2_n, w3_n};

`ifdef AES_RK_STREAM_EN
  logic [127:0] rk_out_q, rk_out_d;
  logic [3:0]   rk_idx_q, rk_idx_d;
  logic         rk_valid_q, rk_valid_d;
`endif

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    rk10_d  = rk10_q;
    valid_d = valid_q;
`ifdef AES_RK_STREAM_EN
    rk_out_d   = rk_out_q;
    rk_idx_d   = rk_idx_q;
    rk_valid_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          w_d     = cipher_key;
          round_d = 4'd1;
          rcon_d  = 8'h01;
          state_d = StExpand;
`ifdef AES_RK_STREAM_EN
          rk_out_d   = cipher_key;
          rk_idx_d   = 4'd0;
          rk_valid_d = 1'b1;
`endif
        end
      end
      StExpand: begin
        w_d     = w_next;
        rcon_d  = rcon_next(rcon_q);
        round_d = round_q + 4'd1;
`ifdef AES_RK_STREAM_EN
        rk_out_d   = w_next;
        rk_idx_d   = round_q;
        rk_valid_d = 1'b1;
`endif
        if (round_q == NrLast) begin
          rk10_d  = w_next;
          valid_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        // start is deliberately ignored here, including on the handoff cycle.
        if (key_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    idle_d = (state_d == StIdle);
    busy_d = (state_d == StExpand);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      w_q     <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
      rk10_q  <= '0;
      valid_q <= 1'b0;
      idle_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      rk10_q  <= rk10_d;
      valid_q <= valid_d;
      idle_q  <= idle_d;
      busy_q  <= busy_d;
    end
  end

`ifdef AES_RK_STREAM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_out_q   <= '0;
      rk_idx_q   <= '0;
      rk_valid_q <= 1'b0;
    end else begin
      rk_out_q   <= rk_out_d;
      rk_idx_q   <= rk_idx_d;
      rk_valid_q <= rk_valid_d;
    end
  end

  assign rk_out   = rk_out_q;
  assign rk_idx   = rk_idx_q;
  assign rk_valid = rk_valid_q;
`endif

  assign idle         = idle_q;
  assign busy         = busy_q;
  assign key_valid    = valid_q;
  assign round_key_10 = rk10_q;

endmodule

// File: tb/tb_aes_key_expand_last.sv
// Directed bench for aes_key_expand_last: FIPS-197 vectors plus handshake corner cases.
module tb_aes_key_expand_last;

  localparam logic [127:0] KeyFips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Rk10Fips = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Rk1Fips = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KeyZero = 128'h0;
  localparam logic [127:0] Rk10Zero = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] rk10;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] cipher_key = '0;
  logic         idle, busy, key_valid;
  logic [127:0] round_key_10;
  logic         key_ready = 1'b0;
`ifdef AES_RK_STREAM_EN
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_valid;
`endif

  int total = 0;
  int bad = 0;

  aes_key_expand_last dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cipher_key(cipher_key),
    .idle(idle),
    .busy(busy),
    .round_key_10(round_key_10),
    .key_valid(key_valid),
    .key_ready(key_ready)
`ifdef AES_RK_STREAM_EN
    ,
    .rk_out(rk_out),
    .rk_idx(rk_idx),
    .rk_valid(rk_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Starts a job, returns cycles from acceptance to key_valid (0 on timeout).
  task automatic run_job(input logic [127:0] key, output int lat, output logic [127:0] rk1);
    lat = 0;
    rk1 = '0;
    @(negedge clk);
    start = 1'b1;
    cipher_key = key;
    @(posedge clk);
    #1;
    start = 1'b0;
    cipher_key = ~key;
    chk("busy_after_accept", {125'h0, idle, busy, key_valid}, 128'b010);
`ifdef AES_RK_STREAM_EN
    chk("stream_key0", rk_out, key);
    chk("stream_idx0", {123'h0, rk_valid, rk_idx}, {123'h0, 1'b1, 4'd0});
`endif
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
`ifdef AES_RK_STREAM_EN
      if (rk_valid && rk_idx == 4'd1) rk1 = rk_out;
`endif
      if (key_valid) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) chk("job_timeout", 128'd0, 128'd1);
  endtask

  task automatic handoff(input logic [127:0] exp);
    @(negedge clk);
    key_ready = 1'b1;
    @(posedge clk);
    #1;
    key_ready = 1'b0;
    chk("handoff_flags", {125'h0, idle, busy, key_valid}, 128'b100);
    chk("handoff_retain", round_key_10, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[2];
    int           lat;
    logic [127:0] rk1;
    logic         stable;
    int           t_first, t_second;
    logic [127:0] r_first, r_second;

    vecs[0] = '{key: KeyFips, rk10: Rk10Fips};
    vecs[1] = '{key: KeyZero, rk10: Rk10Zero};

    #12;
    chk("reset_flags", {125'h0, idle, busy, key_valid}, 128'b100);
    chk("reset_rk10", round_key_10, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 2; i++) begin
      run_job(vecs[i].key, lat, rk1);
      chk("latency", 128'(lat), 128'd10);
      chk("rk10_vec", round_key_10, vecs[i].rk10);
`ifdef AES_RK_STREAM_EN
      if (i == 0) chk("stream_rk1", rk1, Rk1Fips);
`endif
      handoff(vecs[i].rk10);
    end

    // Backpressure with ignored start pulses.
    run_job(KeyFips, lat, rk1);
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = c[0];
      cipher_key = KeyZero;
      @(posedge clk);
      #1;
      if (!key_valid || idle || busy || round_key_10 !== Rk10Fips) stable = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    chk("backpressure_stable", {127'h0, stable}, 128'd1);
    handoff(Rk10Fips);

    // Start with a different key during EXPAND must be ignored.
    @(negedge clk);
    start = 1'b1;
    cipher_key = KeyFips;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    cipher_key = KeyZero;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (key_valid) begin
        lat = 1;
        break;
      end
    end
    chk("ignore_start_expand", round_key_10, Rk10Fips);
    chk("ignore_start_done", {127'h0, key_valid}, 128'd1);
    handoff(Rk10Fips);

    // Asynchronous reset at round 5, then a clean job.
    @(negedge clk);
    start = 1'b1;
    cipher_key = KeyFips;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_flags", {125'h0, idle, busy, key_valid}, 128'b100);
    chk("async_reset_rk10", round_key_10, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(KeyZero, lat, rk1);
    chk("after_reset_latency", 128'(lat), 128'd10);
    chk("after_reset_rk10", round_key_10, Rk10Zero);
    handoff(Rk10Zero);

    // Back-to-back with key_ready tied high.
    @(negedge clk);
    key_ready = 1'b1;
    start = 1'b1;
    cipher_key = KeyFips;
    @(posedge clk);
    #1;
    cipher_key = KeyZero;
    t_first = -1;
    t_second = -1;
    r_first = '0;
    r_second = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (key_valid) begin
        if (t_first < 0) begin
          t_first = n;
          r_first = round_key_10;
        end else begin
          t_second = n;
          r_second = round_key_10;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    key_ready = 1'b0;
    chk("b2b_first", r_first, Rk10Fips);
    chk("b2b_second", r_second, Rk10Zero);
    chk("b2b_first_latency", 128'(t_first), 128'd10);
    chk("b2b_spacing", 128'(t_second - t_first), 128'd12);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
